// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch stage with an in-order prefetch queue. Issues
//            PC-based fetches on a credit basis and presents {instr, pc} to
//            decode over a valid/ready handshake; redirects flush everything.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          req_en_q, req_en_d;
    logic [31:0]   mem_pc_q [DEPTH];
    logic [31:0]   mem_pc_d [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_instr_d [DEPTH];

    logic [CW:0]   credit_sum;
    logic          issue;
    logic          push;
    logic          pop;
    logic          unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    // Queued words, in-flight words and words still to be discarded all hold a credit.
    assign credit_sum = {1'b0, count_q} + {1'b0, outstanding_q} + {1'b0, discard_q};
    assign imem_req   = req_en_q & ~redirect & (credit_sum < (CW+1)'(DEPTH));
    assign imem_addr  = fetch_pc_q;
    assign issue      = imem_req & imem_gnt;

    assign id_valid = (count_q != '0);
    assign id_instr = mem_instr_q[rd_ptr_q];
    assign id_pc    = mem_pc_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        req_en_d      = 1'b1;
        mem_pc_d      = mem_pc_q;
        mem_instr_d   = mem_instr_q;
        push          = 1'b0;
        pop           = 1'b0;

        if (redirect) begin
            // Every in-flight word is dropped exactly once; a same-cycle rvalid
            // consumes one of them here.
            count_d       = '0;
            wr_ptr_d      = rd_ptr_q;
            outstanding_d = '0;
            discard_d     = discard_q + outstanding_q - CW'(imem_rvalid);
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
            resp_pc_d     = {redirect_pc[31:2], 2'b00};
        end else begin
            push = imem_rvalid & (discard_q == '0);
            pop  = id_valid & id_ready;

            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end

            if (imem_rvalid & (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end

            outstanding_d = outstanding_q + CW'(issue) - CW'(push);

            if (push) begin
                mem_pc_d[wr_ptr_q]    = resp_pc_q;
                mem_instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d              = wr_ptr_q + AW'(1);
                resp_pc_d             = resp_pc_q + 32'd4;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end

            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            req_en_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            req_en_q      <= req_en_d;
            mem_pc_q      <= mem_pc_d;
            mem_instr_q   <= mem_instr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Directed self-checking bench for inst_fetch with a small
//            in-order instruction-memory responder (rdata = addr ^ A5A5A5A5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] XMASK  = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    logic        gnt_en;
    logic        hold_resp;
    logic [31:0] pend[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic [31:0] gnt_addr[$];
    int          vectors;
    int          miscompares;

    inst_fetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (2)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pc_at(input int i);
        return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] instr_at(input int i);
        return (i < got_instr.size()) ? got_instr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] gnt_at(input int i);
        return (i < gnt_addr.size()) ? gnt_addr[i] : 32'hDEAD_BEEF;
    endfunction

    // One clock cycle, entered and left at a falling edge; also plays the memory.
    task automatic cyc();
        logic        issued;
        logic [31:0] iaddr;
        logic        popd;
        logic [31:0] ppc;
        logic [31:0] pinstr;
        imem_gnt = gnt_en;
        if (!hold_resp && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0] ^ XMASK;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        issued = imem_req & imem_gnt;
        iaddr  = imem_addr;
        popd   = rst_n & id_valid & id_ready & ~redirect;
        ppc    = id_pc;
        pinstr = id_instr;
        @(posedge clk);
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (imem_rvalid) void'(pend.pop_front());
            if (issued) begin
                pend.push_back(iaddr);
                gnt_addr.push_back(iaddr);
            end
            if (popd) begin
                got_pc.push_back(ppc);
                got_instr.push_back(pinstr);
            end
        end
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && got_pc.size() < n; i++) cyc();
        chk(tag, 32'(got_pc.size() >= n), 32'd1);
    endtask

    task automatic do_reset(input logic ready);
        rst_n    = 1'b0;
        id_ready = ready;
        redirect = 1'b0;
        run(2);
        got_pc.delete();
        got_instr.delete();
        gnt_addr.delete();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;
        gnt_en      = 1'b1;
        hold_resp   = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset(1'b1);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_id_pc",    id_pc,    32'd0);
        chk("rst_id_instr", id_instr, 32'd0);

        // Free-running stream from RESET_PC, wrapping through zero
        rst_n = 1'b1;
        cyc();
        chk("first_req",  32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RST_PC);
        wait_pops("stream_pops", 4, 40);
        chk("stream_pc0",    pc_at(0),    32'hFFFF_FFF8);
        chk("stream_instr0", instr_at(0), 32'h5A5A_5A5D);
        chk("stream_pc1",    pc_at(1),    32'hFFFF_FFFC);
        chk("stream_instr1", instr_at(1), 32'h5A5A_5A59);
        chk("stream_pc2",    pc_at(2),    32'h0000_0000);
        chk("stream_instr2", instr_at(2), 32'hA5A5_A5A5);
        chk("stream_pc3",    pc_at(3),    32'h0000_0004);
        chk("stream_instr3", instr_at(3), 32'hA5A5_A5A1);

        // Decode stalled: credit stops fetch at DEPTH words, head held
        do_reset(1'b0);
        rst_n = 1'b1;
        run(8);
        chk("stall_grants",   32'(gnt_addr.size()), 32'd2);
        chk("stall_req",      32'(imem_req), 32'd0);
        chk("stall_valid",    32'(id_valid), 32'd1);
        chk("stall_pc",       id_pc,    32'hFFFF_FFF8);
        chk("stall_instr",    id_instr, 32'h5A5A_5A5D);
        id_ready = 1'b1;
        wait_pops("resume_pops", 2, 20);
        chk("resume_pc0",     pc_at(0),  32'hFFFF_FFF8);
        chk("resume_pc1",     pc_at(1),  32'hFFFF_FFFC);
        chk("resume_gnt",     gnt_at(2), 32'h0000_0000);

        // Redirect with two fetches in flight; both responses discarded
        do_reset(1'b1);
        hold_resp = 1'b1;
        rst_n     = 1'b1;
        run(3);
        chk("inflight_grants", 32'(gnt_addr.size()), 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        chk("redir_req", 32'(imem_req), 32'd0);
        cyc();
        hold_resp = 1'b0;
        chk("redir_flush_valid", 32'(id_valid), 32'd0);
        wait_pops("redir_pops", 1, 20);
        chk("redir_pc0",    pc_at(0),    32'h0000_0100);
        chk("redir_instr0", instr_at(0), 32'hA5A5_A4A5);
        chk("redir_gnt",    gnt_at(2),   32'h0000_0100);

        // Redirect coinciding with rvalid and a pop
        do_reset(1'b0);
        rst_n = 1'b1;
        run(3);
        chk("coinc_pre_valid", 32'(id_valid), 32'd1);
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        cyc();
        chk("coinc_no_pop", 32'(got_pc.size()), 32'd0);
        chk("coinc_valid",  32'(id_valid), 32'd0);
        wait_pops("coinc_pops", 2, 20);
        chk("coinc_pc0",    pc_at(0),    32'h0000_0200);
        chk("coinc_instr0", instr_at(0), 32'hA5A5_A7A5);
        chk("coinc_pc1",    pc_at(1),    32'h0000_0204);
        chk("coinc_instr1", instr_at(1), 32'hA5A5_A7A1);

        // Reset mid-operation with a queued word and one fetch outstanding
        do_reset(1'b0);
        rst_n = 1'b1;
        run(3);
        hold_resp = 1'b1;
        cyc();
        chk("midrst_pre_valid", 32'(id_valid), 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("midrst_valid", 32'(id_valid), 32'd0);
        chk("midrst_req",   32'(imem_req), 32'd0);
        chk("midrst_pc",    id_pc,    32'd0);
        chk("midrst_instr", id_instr, 32'd0);
        hold_resp = 1'b0;
        got_pc.delete();
        got_instr.delete();
        rst_n = 1'b1;
        cyc();
        chk("midrst_first_req",  32'(imem_req), 32'd1);
        chk("midrst_first_addr", imem_addr, RST_PC);
        id_ready = 1'b1;
        wait_pops("midrst_pops", 1, 20);
        chk("midrst_pc0", pc_at(0), 32'hFFFF_FFF8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
